// File: rtl/vtg_pkg.sv
// Shared constants and the period clamp helper for the variable tick generator.
// Latency: none (package only). Backpressure: none.
package vtg_pkg;

  localparam int unsigned VTG_MIN_PERIOD_DEF = 2;
  localparam int unsigned VTG_PRESCALE_DEF   = 1000;

  // Effective period: anything below the floor runs at the floor.
  function automatic logic [31:0] vtg_clamp(input logic [31:0] period,
                                            input logic [31:0] min_period);
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/vtg_channel.sv
// One tick channel: period counter, latched period, square-wave and tick strobe.
// Latency: outputs registered, 1 clk after the deciding edge. Backpressure: none; adv paces it.
module vtg_channel
  import vtg_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned MIN_PERIOD = VTG_MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             clk_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] eff;
  logic             clk_d, tick_d;

  assign eff = WIDTH'(vtg_clamp(32'(period), 32'(MIN_PERIOD)));

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    tick_d = 1'b0;
    if (!en) begin
      // Parked one step before the wrap so the first adv after enable ticks at once.
      cnt_d = eff - WIDTH'(1);
      per_d = eff;
    end else if (adv) begin
      if (cnt_q == per_q - WIDTH'(1)) begin
        cnt_d  = '0;
        per_d  = eff;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
    clk_d = en && (cnt_d < (per_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      per_q  <= WIDTH'(MIN_PERIOD);
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      clk_o  <= clk_d;
      tick_o <= tick_d;
    end
  end

endmodule

// File: rtl/variable_tick_gen.sv
// Multi-channel programmable-period tick/enable-clock generator; VTG_PRESCALE_EN adds a shared advance divider.
// Latency: outputs registered, 1 clk. Backpressure: none; free-running per channel while en_i is high.
module variable_tick_gen
  import vtg_pkg::*;
#(
  parameter int unsigned CH         = 2,
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned MIN_PERIOD = VTG_MIN_PERIOD_DEF,
  parameter int unsigned PRESCALE   = VTG_PRESCALE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       en_i,
  input  logic [CH*WIDTH-1:0] period_i,
  output logic [CH-1:0]       clk_o,
  output logic [CH-1:0]       tick_o
);

  if (MIN_PERIOD < 2 || MIN_PERIOD >= (1 << WIDTH) || PRESCALE < 1) begin : g_bad_cfg
    $error("variable_tick_gen: illegal MIN_PERIOD/PRESCALE for WIDTH");
  end

  logic adv;

`ifdef VTG_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;

  // Free-running; only reset restarts it, channel enables never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (pre_q == PW'(PRESCALE - 1)) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign adv = (pre_q == PW'(PRESCALE - 1));
`else
  assign adv = 1'b1;
`endif

  for (genvar k = 0; k < CH; k++) begin : g_ch
    vtg_channel #(
      .WIDTH      (WIDTH),
      .MIN_PERIOD (MIN_PERIOD)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .en     (en_i[k]),
      .period (period_i[k*WIDTH +: WIDTH]),
      .clk_o  (clk_o[k]),
      .tick_o (tick_o[k])
    );
  end

endmodule

// File: tb/tb_variable_tick_gen.sv
// Directed bench for variable_tick_gen (default build, no prescaler), CH=2, WIDTH=10.
module tb_variable_tick_gen;

  localparam int unsigned CH    = 2;
  localparam int unsigned WIDTH = 10;

  logic                clk;
  logic                rst_n;
  logic [CH-1:0]       en_i;
  logic [CH*WIDTH-1:0] period_i;
  logic [CH-1:0]       clk_o;
  logic [CH-1:0]       tick_o;

  int n_assert;
  int n_fail;

  variable_tick_gen #(
    .CH         (CH),
    .WIDTH      (WIDTH),
    .MIN_PERIOD (2),
    .PRESCALE   (1000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .period_i (period_i),
    .clk_o    (clk_o),
    .tick_o   (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Samples the current cycle then advances, n times; ends one edge past the window.
  task automatic measure(input int n, output int hi0, output int tk0,
                         output int hi1, output int tk1);
    hi0 = 0; tk0 = 0; hi1 = 0; tk1 = 0;
    for (int i = 0; i < n; i++) begin
      hi0 += int'(clk_o[0]);
      tk0 += int'(tick_o[0]);
      hi1 += int'(clk_o[1]);
      tk1 += int'(tick_o[1]);
      step();
    end
  endtask

  task automatic set_period(input int k, input int p);
    period_i[k*WIDTH +: WIDTH] = WIDTH'(p);
  endtask

  initial begin
    int hi0, tk0, hi1, tk1;
    int first0, first1;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    en_i     = '0;
    period_i = '0;

    // Asynchronous reset with no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    chk("reset_clk_o", int'(clk_o), 0);
    chk("reset_tick_o", int'(tick_o), 0);
    #10 rst_n = 1'b1;
    step();

    // Load periods while disabled, then enable: both channels wrap immediately
    set_period(0, 10);
    set_period(1, 3);
    step();
    en_i = 2'b11;
    step();
    chk("en_rise_tick", int'(tick_o), 3);
    chk("en_rise_clk", int'(clk_o), 3);

    // Period 10 on ch0 and 3 on ch1 over a 10-cycle window
    measure(10, hi0, tk0, hi1, tk1);
    chk("p10_high", hi0, 5);
    chk("p10_ticks", tk0, 1);
    chk("p3_high", hi1, 4);
    chk("p3_ticks", tk1, 4);
    chk("p10_wrap", int'(tick_o[0]), 1);

    // Change 10 -> 4 at cnt=3: current period still finishes at 10
    step(); step(); step();
    set_period(0, 4);
    measure(7, hi0, tk0, hi1, tk1);
    chk("chg_tail_high", hi0, 2);
    chk("chg_tail_ticks", tk0, 0);
    chk("chg_wrap_at_10", int'(tick_o[0]), 1);
    measure(8, hi0, tk0, hi1, tk1);
    chk("p4_high", hi0, 4);
    chk("p4_ticks", tk0, 2);

    // Max period 1023: first the pending period 4 completes
    set_period(0, 1023);
    measure(4, hi0, tk0, hi1, tk1);
    chk("p4_last_ticks", tk0, 1);
    measure(1023, hi0, tk0, hi1, tk1);
    chk("p1023_high", hi0, 511);
    chk("p1023_ticks", tk0, 1);
    chk("p1023_wrap", int'(tick_o[0]), 1);

    // Period 0 clamps to 2
    set_period(0, 0);
    measure(1023, hi0, tk0, hi1, tk1);
    measure(6, hi0, tk0, hi1, tk1);
    chk("p0_clamp_high", hi0, 3);
    chk("p0_clamp_ticks", tk0, 3);

    // Disable mid-period at cnt=6; ch1 re-enables with period 1 (clamps to 2)
    set_period(0, 10);
    measure(2, hi0, tk0, hi1, tk1);
    for (int i = 0; i < 6; i++) step();
    en_i = 2'b00;
    set_period(0, 6);
    set_period(1, 1);
    step();
    chk("dis_clk_o", int'(clk_o), 0);
    chk("dis_tick_o", int'(tick_o), 0);
    measure(15, hi0, tk0, hi1, tk1);
    chk("dis_high", hi0, 0);
    chk("dis_ticks0", tk0, 0);
    chk("dis_ticks1", tk1, 0);
    en_i = 2'b11;
    step();
    chk("reen_tick", int'(tick_o), 3);
    chk("reen_clk", int'(clk_o), 3);
    measure(6, hi0, tk0, hi1, tk1);
    chk("p6_high", hi0, 3);
    chk("p6_ticks", tk0, 1);
    chk("p1_clamp_high", hi1, 3);
    chk("p1_clamp_ticks", tk1, 3);

    // Asynchronous reset between edges, mid-period
    step(); step();
    chk("pre_rst_clk", int'(clk_o), 3);
    chk("pre_rst_tick", int'(tick_o), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk", int'(clk_o), 0);
    chk("async_rst_tick", int'(tick_o), 0);
    step();
    #1 rst_n = 1'b1;
    first0 = -1;
    first1 = -1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (tick_o[0] && first0 < 0) first0 = i;
      if (tick_o[1] && first1 < 0) first1 = i;
    end
    chk("post_rst_first_tick0", first0, 2);
    chk("post_rst_first_tick1", first1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
